// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of digit steps needed to cover the full operand width.
    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-step configuration still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        int unsigned n;
        n = num_digits(width, digit);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dif;
    logic             bor;
    logic             ovf;

    modport master (
        output start, A, B, bin,
        input  busy, done, dif, bor, ovf
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, dif, bor, ovf
    );
endinterface

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bi, bo = borrow out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: A - B - bin over WIDTH bits, DIGIT bits per clock,
// with a registered borrow chain between digit steps.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned NumDigits = num_digits(WIDTH, DIGIT);
    localparam int unsigned CntW      = cnt_width(WIDTH, DIGIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_e            state_q, state_d;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  res_q, res_next;
    logic [WIDTH-1:0]  dif_q;
    logic [CntW-1:0]   cnt_q;
    logic              brw_q;
    logic              a_msb_q, b_msb_q;
    logic              busy_q, done_q, bor_q, ovf_q;
    logic              ovf_next;
    logic [DIGIT:0]    chain;
    logic [DIGIT-1:0]  dig;

    // Digit slice: DIGIT cells rippling from the registered borrow.
    assign chain[0] = brw_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fs_cell u_fs_cell (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .bi (chain[i]),
            .d  (dig[i]),
            .bo (chain[i+1])
        );
    end

    // New digit enters at the MSB end; after N steps the LSB digit sits at bit 0.
    assign res_next = WIDTH'({dig, res_q} >> DIGIT);
    assign last     = (state_q == RUN) && (cnt_q == LastCnt);
    assign ovf_next = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; accept marks the edge that captures a new operation.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand shift registers, borrow register, partial result and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            res_q   <= '0;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            a_msb_q <= bus.A[WIDTH-1];
            b_msb_q <= bus.B[WIDTH-1];
        end else if (state_q == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            res_q <= res_next;
            brw_q <= chain[DIGIT];
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Visible results change only on DONE entry; handshake flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dif_q  <= '0;
            bor_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (last) begin
                dif_q <= res_next;
                bor_q <= chain[DIGIT];
                ovf_q <= ovf_next;
            end
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dif  = dif_q;
    assign bus.bor  = bor_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases at WIDTH 8/1 and a random
// regression at WIDTH 16 for every legal DIGIT, against an arithmetic model.
module tb_serial_subtractor;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_r;
    int   n_vec;
    int   n_err;
    bit [4:0] rnd_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction in unsigned and signed views.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic bi);
        exp_t   r;
        longint m, ua, ub, sa, sb, diff, sdiff, half;
        m     = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(a) & m;
        ub    = longint'(b) & m;
        diff  = ua - ub - longint'(bi);
        r.d   = 16'(diff & m);
        r.bo  = (diff < 0);
        sa    = (ua >= half) ? ua - (m + 1) : ua;
        sb    = (ub >= half) ? ub - (m + 1) : ub;
        sdiff = sa - sb - longint'(bi);
        r.ov  = (sdiff < -half) || (sdiff >= half);
        return r;
    endfunction

    serial_subtractor_if #(.WIDTH(8)) bus81 ();
    serial_subtractor_if #(.WIDTH(8)) bus84 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut81 (.clk(clk), .rst_n(rst_a), .bus(bus81));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut84 (.clk(clk), .rst_n(rst_a), .bus(bus84));
    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_dut1  (.clk(clk), .rst_n(rst_a), .bus(bus1));

    // Random regression, one independent driver per DIGIT at WIDTH 16.
    for (genvar k = 0; k < 5; k++) begin : g_rnd
        localparam int unsigned D = 1 << k;
        localparam int unsigned N = 16 / D;

        serial_subtractor_if #(.WIDTH(16)) bus ();
        serial_subtractor #(.WIDTH(16), .DIGIT(D)) u_dut (.clk(clk), .rst_n(rst_r), .bus(bus));

        initial begin
            exp_t        prev, e;
            int          c, bc;
            logic [15:0] a, b;
            logic        bi;
            bit          b2b;
            bus.start = 1'b0;
            bus.A     = '0;
            bus.B     = '0;
            bus.bin   = 1'b0;
            prev      = '0;
            b2b       = 1'b0;
            wait (rst_r === 1'b1);
            @(negedge clk);
            for (int i = 0; i < 24; i++) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                bi = 1'($urandom);
                if (!b2b) begin
                    @(negedge clk);
                    check($sformatf("d%0d_done_pulse", D), 32'(bus.done), 32'd0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                bus.A     = a;
                bus.B     = b;
                bus.bin   = bi;
                bus.start = 1'b1;
                e  = model(16, a, b, bi);
                c  = 0;
                bc = 0;
                do begin
                    @(negedge clk);
                    c++;
                    bus.start = 1'b0;
                    bus.A     = 16'($urandom);
                    bus.B     = 16'($urandom);
                    bus.bin   = 1'($urandom);
                    if (bus.busy) bc++;
                    if (!bus.done) begin
                        check($sformatf("d%0d_hold", D), 32'({bus.dif, bus.bor, bus.ovf}),
                              32'(prev));
                    end
                end while (!bus.done && c < int'(N) + 8);
                check($sformatf("d%0d_latency", D), 32'(c - 1), 32'(N));
                check($sformatf("d%0d_busy_cycles", D), 32'(bc), 32'(N));
                check($sformatf("d%0d_result", D), 32'({bus.dif, bus.bor, bus.ovf}), 32'(e));
                prev = e;
                b2b  = ($urandom_range(0, 2) == 0);
            end
            rnd_done[k] = 1'b1;
        end
    end

    // Drive both WIDTH-8 instances with the same operation and check both.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t e;
        int   l1, l4, b1, b4, d1, d4;
        e  = model(8, 16'(a), 16'(b), bi);
        l1 = 0; l4 = 0; b1 = 0; b4 = 0; d1 = 0; d4 = 0;
        @(negedge clk);
        bus81.A = a; bus81.B = b; bus81.bin = bi; bus81.start = 1'b1;
        bus84.A = a; bus84.B = b; bus84.bin = bi; bus84.start = 1'b1;
        for (int c = 1; c <= 20 && (l1 == 0 || l4 == 0); c++) begin
            @(negedge clk);
            bus81.start = 1'b0;
            bus84.start = 1'b0;
            if (bus81.busy) b1++;
            if (bus84.busy) b4++;
            if (bus81.done) begin
                d1++;
                if (l1 == 0) begin
                    l1 = c;
                    check("w8d1_result", 32'({bus81.dif, bus81.bor, bus81.ovf}),
                          32'({e.d[7:0], e.bo, e.ov}));
                end
            end
            if (bus84.done) begin
                d4++;
                if (l4 == 0) begin
                    l4 = c;
                    check("w8d4_result", 32'({bus84.dif, bus84.bor, bus84.ovf}),
                          32'({e.d[7:0], e.bo, e.ov}));
                end
            end
        end
        check("w8d1_latency", 32'(l1 - 1), 32'd8);
        check("w8d4_latency", 32'(l4 - 1), 32'd2);
        check("w8d1_busy_cycles", 32'(b1), 32'd8);
        check("w8d4_busy_cycles", 32'(b4), 32'd2);
        check("w8d1_done_cycles", 32'(d1), 32'd1);
        check("w8d4_done_cycles", 32'(d4), 32'd1);
    endtask

    task automatic op1(input logic a, input logic b, input logic bi);
        exp_t e;
        int   c;
        e = model(1, 16'(a), 16'(b), bi);
        @(negedge clk);
        bus1.A = a; bus1.B = b; bus1.bin = bi; bus1.start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            bus1.start = 1'b0;
        end while (!bus1.done && c < 6);
        check("w1_latency", 32'(c - 1), 32'd1);
        check($sformatf("w1_result_%0d%0d%0d", a, b, bi), 32'({bus1.dif, bus1.bor, bus1.ovf}),
              32'({e.d[0], e.bo, e.ov}));
    endtask

    initial begin
        int cnt;
        n_vec    = 0;
        n_err    = 0;
        rnd_done = '0;
        rst_a    = 1'b1;
        rst_r    = 1'b1;
        bus81.start = 1'b0; bus81.A = '0; bus81.B = '0; bus81.bin = 1'b0;
        bus84.start = 1'b0; bus84.A = '0; bus84.B = '0; bus84.bin = 1'b0;
        bus1.start  = 1'b0; bus1.A  = '0; bus1.B  = '0; bus1.bin  = 1'b0;
        #1;
        rst_a = 1'b0;
        rst_r = 1'b0;
        #1;
        check("reset_w8d1", 32'({bus81.busy, bus81.done, bus81.dif, bus81.bor, bus81.ovf}), 32'd0);
        check("reset_w8d4", 32'({bus84.busy, bus84.done, bus84.dif, bus84.bor, bus84.ovf}), 32'd0);
        check("reset_w1", 32'({bus1.busy, bus1.done, bus1.dif, bus1.bor, bus1.ovf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        rst_r = 1'b1;

        op8(8'h05, 8'h03, 1'b0);
        op8(8'h03, 8'h05, 1'b0);
        op8(8'h80, 8'h01, 1'b0);
        op8(8'h00, 8'hFF, 1'b1);
        op8(8'h10, 8'h01, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        // DIGIT 4: start held through RUN is ignored; start in DONE is accepted.
        @(negedge clk);
        bus84.A = 8'h10; bus84.B = 8'h01; bus84.bin = 1'b0; bus84.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c < 3) begin
                check("held_run_done", 32'(bus84.done), 32'd0);
                bus84.A   = 8'($urandom);
                bus84.B   = 8'($urandom);
                bus84.bin = 1'($urandom);
            end
            if (c == 3) begin
                check("b2b_first_done", 32'(bus84.done), 32'd1);
                check("b2b_first_dif", 32'(bus84.dif), 32'h0F);
                bus84.A = 8'h22; bus84.B = 8'h11; bus84.bin = 1'b0;
            end
            if (c == 4) begin
                bus84.start = 1'b0;
                bus84.A     = 8'hFF;
            end
            if (c == 4 || c == 5) begin
                check("b2b_gap_done", 32'(bus84.done), 32'd0);
                check("b2b_gap_dif_held", 32'(bus84.dif), 32'h0F);
            end
            if (c == 6) begin
                check("b2b_second_done", 32'(bus84.done), 32'd1);
                check("b2b_second_dif", 32'(bus84.dif), 32'h11);
            end
            if (c == 7) check("b2b_done_pulse", 32'(bus84.done), 32'd0);
        end

        // Reset asserted mid-RUN on the DIGIT 1 instance.
        @(negedge clk);
        bus81.A = 8'h33; bus81.B = 8'h11; bus81.bin = 1'b0; bus81.start = 1'b1;
        @(negedge clk);
        bus81.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", 32'(bus81.busy), 32'd1);
        #2;
        rst_a = 1'b0;
        #1;
        check("rst_outputs", 32'({bus81.busy, bus81.done, bus81.dif, bus81.bor, bus81.ovf}), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus81.done || bus81.busy) cnt++;
        end
        check("rst_no_done", 32'(cnt), 32'd0);
        op8(8'hA5, 8'h5A, 1'b1);

        for (int i = 0; i < 20000 && !(&rnd_done); i++) @(negedge clk);
        check("rnd_complete", 32'(rnd_done), 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor: computes A − B − bin over WIDTH bits, DIGIT bits per clock, through a registered borrow chain. It is the sequential, width-generalised successor to the one-bit full subtractor cell. It serves datapaths that trade latency for area, and it adds a start/done handshake, borrow-out, and signed-overflow flags.

## Interface
- WIDTH, default 8: operand and result width in bits; WIDTH ≥ 1.
- DIGIT, default 1: bits processed per cycle; WIDTH must be an exact multiple of DIGIT. Elaboration error otherwise.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a subtraction; sampled only when not busy.
- A  in  WIDTH  minuend, captured on the accepting edge.
- B  in  WIDTH  subtrahend, captured on the accepting edge.
- bin  in  1  borrow-in, captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: results valid.
- dif  out  WIDTH  (A − B − bin) mod 2^WIDTH.
- bor  out  1  unsigned borrow-out: 1 iff A < B + bin.
- ovf  out  1  two's-complement overflow: A[MSB] ≠ B[MSB] and dif[MSB] ≠ A[MSB].

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with start = 1: capture A, B and bin into shift registers; clear the digit counter; go to RUN.
- DONE with start = 0: go to IDLE.
- RUN, each cycle:
  - The low DIGIT bits of the A and B shift registers pass through DIGIT chained one-bit subtractor cells. The first cell takes the borrow register; each later cell takes the previous cell's borrow.
  - The DIGIT difference bits shift into the result register from the MSB side.
  - The borrow register takes the last cell's borrow; the operand registers shift right by DIGIT.
- The counter runs 0..N−1, with N = WIDTH/DIGIT. When count = N−1, go to DONE.
- On entry to DONE:
  - dif takes the assembled result.
  - bor takes the final borrow.
  - ovf is computed from the captured MSBs of A and B and dif[MSB].
- start while in RUN is ignored; operands and result are untouched.
- dif, bor and ovf hold their values until the next DONE entry. They do not change during a later RUN.
- Reset values: busy = 0, done = 0, dif = 0, bor = 0, ovf = 0. Counter, borrow register and shift registers are also cleared.
- Reset asserted mid-RUN: abort immediately to IDLE; no done pulse. Operation restarts only on a new start after reset release.

## Timing
- Latency: done is high in the cycle following the edge N clocks after the accepting edge. Examples: WIDTH = 8, DIGIT = 1 gives 8 clocks; DIGIT = 4 gives 2.
- busy is high exactly in the N cycles of RUN. It is low in the DONE cycle.
- done is high exactly one cycle per accepted operation.
- Back-to-back: start = 1 in the DONE cycle is accepted. The next result arrives N+1 cycles after the previous one, so throughput is one result per N+1 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_subtractor_pkg:
  - state enum {IDLE, RUN, DONE};
  - function returning N for a given WIDTH and DIGIT;
  - counter width $clog2(N), minimum 1.
- Sub-module fs_cell: combinational one-bit full subtractor with inputs a, b, bi and outputs d, bo. It is instantiated DIGIT times in a generate loop.
- The top level holds the FSM, counter, shift registers, borrow register and output registers.

## Test plan
- WIDTH 8, DIGIT 1: A = 0x05, B = 0x03, bin = 0 → dif = 0x02, bor = 0, ovf = 0. done 8 clocks after accept; busy high for exactly 8 cycles.
- A = 0x03, B = 0x05, bin = 0 → dif = 0xFE, bor = 1, ovf = 0. A = 0x80, B = 0x01 → dif = 0x7F, bor = 0, ovf = 1. A = 0x00, B = 0xFF, bin = 1 → dif = 0x00, bor = 1, ovf = 0.
- WIDTH 1, DIGIT 1: all 8 combinations of A, B, bin → dif and bor match the full-subtractor truth table. Example: 0,1,1 → dif = 0, bor = 1.
- WIDTH 8, DIGIT 4:
  - A = 0x10, B = 0x01 → dif = 0x0F with latency 2.
  - start held high with changing operands during RUN → ignored.
  - start in the DONE cycle → second result 3 clocks after the first.
- rst_n pulsed low mid-RUN → all outputs 0 immediately, no done pulse. A subsequent start → correct result.
- Random regression at WIDTH 16, DIGIT 1/2/4/8/16: dif, bor and ovf checked against a reference model, with prior outputs held between operations.
